// File: rtl/axi_mem_slave_param_if.sv
// Bus bundle for axi_mem_slave_param: AR/R read channels and AW/W/B write
// channels with separate ID/LEN/ADDR fields. WSTRB exists only when the
// AXI_MEM_WSTRB_EN macro is defined.
interface axi_mem_slave_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [ID_W-1:0]   ARID;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [ID_W-1:0]   RID;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [ID_W-1:0]   AWID;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;
`ifdef AXI_MEM_WSTRB_EN
  logic [DATA_W/8-1:0] WSTRB;
`endif
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;

  modport slave (
`ifdef AXI_MEM_WSTRB_EN
    input  WSTRB,
`endif
    input  ARVALID, ARADDR, ARLEN, ARID, RREADY,
    input  AWVALID, AWADDR, AWID, WVALID, WDATA, WLAST, BREADY,
    output ARREADY, RVALID, RDATA, RID, RRESP, RLAST,
    output AWREADY, WREADY, BVALID, BID, BRESP
  );

  modport master (
`ifdef AXI_MEM_WSTRB_EN
    output WSTRB,
`endif
    output ARVALID, ARADDR, ARLEN, ARID, RREADY,
    output AWVALID, AWADDR, AWID, WVALID, WDATA, WLAST, BREADY,
    input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST,
    input  AWREADY, WREADY, BVALID, BID, BRESP
  );
endinterface

// File: rtl/axi_mem_slave_param.sv
// Parametrised burst memory slave with independent read and write FSMs,
// SLVERR on out-of-range beats, programmable recovery delay and a read stall
// while the reader points at the word the writer is about to write.
// Optional macro AXI_MEM_WSTRB_EN enables per-byte write strobes (WSTRB).
module axi_mem_slave_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int DLY_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  axi_mem_slave_param_if.slave bus,
  input  logic [DLY_W-1:0]   DELAY,
  output logic               RIDLE,
  output logic               WIDLE
);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_DLY} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_DLY} w_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  r_state_t          r_state, r_nxt;
  logic              ar_rdy, rvalid, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   r_id;
  logic [LEN_W-1:0]  r_len, r_cnt, ld_cnt, ld_len;
  logic [PTR_W-1:0]  r_ptr, ld_ptr;
  logic [DLY_W-1:0]  r_dly;
  logic              ar_hs, r_hs, r_ld, r_fire, rd_oor;

  w_state_t          w_state, w_nxt;
  logic              aw_rdy, w_rdy, bvalid, w_err;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   w_id;
  logic [PTR_W-1:0]  w_ptr;
  logic [DLY_W-1:0]  w_dly;
  logic              aw_hs, w_hs, b_hs, w_oor, w_en;

  assign bus.ARREADY = ar_rdy;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata;
  assign bus.RID     = r_id;
  assign bus.RRESP   = rresp;
  assign bus.RLAST   = rlast;
  assign bus.AWREADY = aw_rdy;
  assign bus.WREADY  = w_rdy;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = w_id;
  assign bus.BRESP   = bresp;
  assign RIDLE       = (r_state == R_IDLE);
  assign WIDLE       = (w_state == W_IDLE);

  // Read next state and the pointer/count of the beat to present next
  always_comb begin
    r_nxt  = r_state;
    ar_hs  = ar_rdy && bus.ARVALID;
    r_hs   = rvalid && bus.RREADY;
    ld_ptr = r_ptr;
    ld_cnt = r_cnt;
    ld_len = r_len;
    r_ld   = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        r_nxt  = R_DATA;
        ld_ptr = {1'b0, bus.ARADDR};
        ld_cnt = '0;
        ld_len = bus.ARLEN;
        r_ld   = 1'b1;
      end
      R_DATA: if (r_hs) begin
        if (rlast) r_nxt = (DELAY == '0) ? R_IDLE : R_DLY;
        else begin
          ld_ptr = r_ptr + 1'b1;
          ld_cnt = r_cnt + 1'b1;
          r_ld   = 1'b1;
        end
      end else if (!rvalid) begin
        r_ld = 1'b1;
      end
      R_DLY:   if (r_dly == DLY_W'(1)) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
    // A pending beat waits while the writer is about to fill that same word
    r_fire = r_ld && !((w_state == W_DATA) && (w_ptr == ld_ptr));
    rd_oor = (ld_ptr >= DEPTH);
  end

  // Read state register and registered AR ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b0;
    end else begin
      r_state <= r_nxt;
      ar_rdy  <= (r_nxt == R_IDLE);
    end
  end

  // Read datapath: burst bookkeeping, registered R beat, recovery counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
      r_id   <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_dly  <= '0;
    end else begin
      if (ar_hs) begin
        r_id  <= bus.ARID;
        r_len <= bus.ARLEN;
      end
      if (r_ld) begin
        r_ptr <= ld_ptr;
        r_cnt <= ld_cnt;
      end
      if (r_fire) begin
        rvalid <= 1'b1;
        rlast  <= (ld_cnt == ld_len);
        rdata  <= rd_oor ? '0 : mem[ld_ptr[ADDR_W-1:0]];
        rresp  <= rd_oor ? 2'b10 : 2'b00;
      end else if (r_hs) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
      if (r_hs && rlast && (DELAY != '0)) r_dly <= DELAY;
      else if (r_state == R_DLY)          r_dly <= r_dly - 1'b1;
    end
  end

  // Write next state and memory write enable
  always_comb begin
    w_nxt = w_state;
    aw_hs = aw_rdy && bus.AWVALID;
    w_hs  = w_rdy && bus.WVALID;
    b_hs  = bvalid && bus.BREADY;
    case (w_state)
      W_IDLE:  if (aw_hs) w_nxt = W_DATA;
      W_DATA:  if (w_hs && bus.WLAST) w_nxt = W_RESP;
      W_RESP:  if (b_hs) w_nxt = (DELAY == '0) ? W_IDLE : W_DLY;
      W_DLY:   if (w_dly == DLY_W'(1)) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
    w_oor = (w_ptr >= DEPTH);
    w_en  = w_hs && !w_oor;
  end

  // Write state register and registered AW/W ready and B valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      aw_rdy  <= 1'b0;
      w_rdy   <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_nxt;
      aw_rdy  <= (w_nxt == W_IDLE);
      w_rdy   <= (w_nxt == W_DATA);
      bvalid  <= (w_nxt == W_RESP);
    end
  end

  // Write datapath: pointer (saturating, never wraps), sticky error, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr <= '0;
      w_id  <= '0;
      w_err <= 1'b0;
      bresp <= 2'b00;
      w_dly <= '0;
    end else begin
      if (aw_hs) begin
        w_ptr <= {1'b0, bus.AWADDR};
        w_id  <= bus.AWID;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        if (!(&w_ptr)) w_ptr <= w_ptr + 1'b1;
        if (w_oor)     w_err <= 1'b1;
        if (bus.WLAST) bresp <= (w_err || w_oor) ? 2'b10 : 2'b00;
      end
      if (b_hs && (DELAY != '0)) w_dly <= DELAY;
      else if (w_state == W_DLY) w_dly <= w_dly - 1'b1;
    end
  end

  // Memory array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_en) begin
`ifdef AXI_MEM_WSTRB_EN
      for (int i = 0; i < DATA_W/8; i++)
        if (bus.WSTRB[i]) mem[w_ptr[ADDR_W-1:0]][i*8 +: 8] <= bus.WDATA[i*8 +: 8];
`else
      mem[w_ptr[ADDR_W-1:0]] <= bus.WDATA;
`endif
    end
  end
endmodule

// File: tb/tb_axi_mem_slave_param.sv
// Scoreboard bench for axi_mem_slave_param: the driver pushes expected R beats
// and B responses from a word-array reference model; a negedge monitor pops
// and compares on every R/B handshake.
module tb_axi_mem_slave_param;
  localparam int DEPTH = 256;
  localparam int LIM   = 200;

  typedef struct packed {logic [7:0] d; logic [3:0] id; logic [1:0] resp; logic last;} rexp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] delay = '0;
  logic       ridle, widle;
  int         rr_mode = 0;
  int         br_mode = 0;
  int         errors = 0;
  int         checks = 0;

  rexp_t      rq[$];
  bexp_t      bq[$];
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wbuf[$];

  axi_mem_slave_param_if #(.DATA_W(8), .ADDR_W(8), .ID_W(4), .LEN_W(4)) ifc ();

  axi_mem_slave_param #(
    .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(DEPTH), .ID_W(4), .LEN_W(4), .DLY_W(5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (ifc),
    .DELAY (delay),
    .RIDLE (ridle),
    .WIDLE (widle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // RREADY/BREADY generator: always, random, 1-0-0-1 pattern, or held low
  initial begin
    int pi = 0;
    logic [3:0] pat = 4'b1001;
    ifc.RREADY = 1'b0;
    ifc.BREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_mode != 2) pi = 0;
      case (rr_mode)
        0: ifc.RREADY = 1'b1;
        1: ifc.RREADY = 1'($urandom_range(0, 1));
        2: begin ifc.RREADY = pat[pi % 4]; pi++; end
        default: ifc.RREADY = 1'b0;
      endcase
      ifc.BREADY = (br_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pops on handshakes plus hold-stability during stalls
  rexp_t r_hold, r_exp;
  bexp_t b_hold, b_exp;
  bit    r_stall = 0, b_stall = 0;
  always @(negedge clk) begin
    if (!rst) begin
      r_stall = 0;
      b_stall = 0;
    end else begin
      if (r_stall) chk("r_hold", {ifc.RVALID, ifc.RDATA, ifc.RID, ifc.RRESP, ifc.RLAST}, {1'b1, r_hold});
      if (b_stall) chk("b_hold", {ifc.BVALID, ifc.BID, ifc.BRESP}, {1'b1, b_hold});
      r_stall = ifc.RVALID && !ifc.RREADY;
      b_stall = ifc.BVALID && !ifc.BREADY;
      r_hold  = {ifc.RDATA, ifc.RID, ifc.RRESP, ifc.RLAST};
      b_hold  = {ifc.BID, ifc.BRESP};
      if (ifc.RVALID && ifc.RREADY) begin
        if (rq.size() == 0) tmo("r_unexpected_beat");
        else begin
          r_exp = rq.pop_front();
          chk("r_beat", {ifc.RDATA, ifc.RID, ifc.RRESP, ifc.RLAST}, r_exp);
        end
      end
      if (ifc.BVALID && ifc.BREADY) begin
        if (bq.size() == 0) tmo("b_unexpected_resp");
        else begin
          b_exp = bq.pop_front();
          chk("b_resp", {ifc.BID, ifc.BRESP}, b_exp);
        end
      end
    end
  end

  function automatic void model_read(input int addr, input int len, input int id);
    for (int i = 0; i <= len; i++) begin
      rexp_t e;
      e.id   = 4'(id);
      e.last = (i == len);
      if (addr + i >= DEPTH) begin e.d = 8'h00; e.resp = 2'b10; end
      else begin e.d = ref_mem[addr + i]; e.resp = 2'b00; end
      rq.push_back(e);
    end
  endfunction

  function automatic void model_write(input int addr, input int id);
    bexp_t e;
    bit err = 0;
    for (int i = 0; i < wbuf.size(); i++) begin
      if (addr + i >= DEPTH) err = 1;
      else ref_mem[addr + i] = wbuf[i];
    end
    e.id   = 4'(id);
    e.resp = err ? 2'b10 : 2'b00;
    bq.push_back(e);
  endfunction

  task automatic ar_req(input int addr, input int len, input int id);
    int n = 0;
    ifc.ARVALID = 1'b1; ifc.ARADDR = 8'(addr); ifc.ARLEN = 4'(len); ifc.ARID = 4'(id);
    @(negedge clk);
    while (!ifc.ARREADY && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) tmo("ar_wait");
    @(posedge clk); #1;
    ifc.ARVALID = 1'b0;
  endtask

  task automatic aw_req(input int addr, input int id);
    int n = 0;
    ifc.AWVALID = 1'b1; ifc.AWADDR = 8'(addr); ifc.AWID = 4'(id);
    @(negedge clk);
    while (!ifc.AWREADY && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) tmo("aw_wait");
    @(posedge clk); #1;
    ifc.AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [7:0] d, input logic last);
    int n = 0;
    ifc.WVALID = 1'b1; ifc.WDATA = d; ifc.WLAST = last;
    @(negedge clk);
    while (!ifc.WREADY && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) tmo("w_wait");
    @(posedge clk); #1;
    ifc.WVALID = 1'b0; ifc.WLAST = 1'b0;
  endtask

  task automatic wait_b(input int dly);
    int n = 0, c = 0;
    @(negedge clk);
    chk("b_first_cycle", ifc.BVALID, 1);
    while (!(ifc.BVALID && ifc.BREADY) && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) tmo("b_wait");
    else begin
      @(negedge clk);
      while (!ifc.AWREADY && c < LIM) begin c++; @(negedge clk); end
      chk("w_recovery", c, dly);
      chk("widle_after", widle, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_r(input int dly, input bit first_chk);
    int n = 0, c = 0;
    @(negedge clk);
    if (first_chk) chk("r_first_cycle", ifc.RVALID, 1);
    while (!(ifc.RVALID && ifc.RREADY && ifc.RLAST) && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) tmo("r_last_wait");
    else begin
      @(negedge clk);
      while (!ifc.ARREADY && c < LIM) begin c++; @(negedge clk); end
      chk("r_recovery", c, dly);
      chk("ridle_after", ridle, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rq_empty();
    int n = 0;
    while (rq.size() != 0 && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) tmo("rq_drain");
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int addr, input int id);
    model_write(addr, id);
    aw_req(addr, id);
    for (int i = 0; i < wbuf.size(); i++) w_beat(wbuf[i], (i == wbuf.size() - 1));
    wait_b(int'(delay));
  endtask

  task automatic do_read(input int addr, input int len, input int id);
    model_read(addr, len, id);
    ar_req(addr, len, id);
    wait_r(int'(delay), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.ARVALID = 0; ifc.ARADDR = '0; ifc.ARLEN = '0; ifc.ARID = '0;
    ifc.AWVALID = 0; ifc.AWADDR = '0; ifc.AWID = '0;
    ifc.WVALID = 0; ifc.WDATA = '0; ifc.WLAST = 0;
`ifdef AXI_MEM_WSTRB_EN
    ifc.WSTRB = '1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {ifc.ARREADY, ifc.RVALID, ifc.AWREADY, ifc.WREADY, ifc.BVALID, ridle, widle}, 7'b0000011);
    chk("rst_data", {ifc.RDATA, ifc.RID, ifc.RRESP, ifc.RLAST, ifc.BID, ifc.BRESP}, 21'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Known contents everywhere: 16 bursts of 16 words
    for (int b = 0; b < 16; b++) begin
      delay = 5'($urandom_range(0, 2));
      wbuf.delete();
      for (int i = 0; i < 16; i++) wbuf.push_back(8'($urandom));
      do_write(b * 16, b);
    end

    // Basic 3-beat write then read back
    delay = 0;
    wbuf = '{8'hA1, 8'hA2, 8'hA3};
    do_write(8'h10, 3);
    do_read(8'h10, 2, 5);

    // Burst crossing the top of memory
    do_read(8'hFE, 3, 6);
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(8'hFE, 2);
    do_read(8'h00, 0, 1);
    do_read(8'hFE, 1, 4);

    // RREADY stalls 1,0,0,1
    rr_mode = 2;
    do_read(8'h30, 3, 7);
    rr_mode = 0;

    // Recovery delay of 5 on both channels
    delay = 5;
    wbuf = '{8'h5A, 8'hC3};
    do_write(8'h60, 8);
    do_read(8'h60, 1, 9);

    // Read pointer meets in-progress write pointer
    delay = 0;
    wbuf = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    model_write(8'h1E, 10);
    aw_req(8'h1E, 10);
    w_beat(8'hD0, 0);
    w_beat(8'hD1, 0);
    model_read(8'h20, 1, 11);
    ar_req(8'h20, 1, 11);
    repeat (4) begin
      @(negedge clk);
      chk("collision_hold", ifc.RVALID, 0);
    end
    @(posedge clk); #1;
    w_beat(8'hD2, 0);
    w_beat(8'hD3, 1);
    wait_b(0);
    wait_rq_empty();

    // Randomised mixed traffic
    for (int t = 0; t < 40; t++) begin
      int addr, len;
      delay   = 5'($urandom_range(0, 3));
      rr_mode = $urandom_range(0, 1);
      br_mode = $urandom_range(0, 1);
      addr    = $urandom_range(0, 255);
      len     = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        for (int i = 0; i <= len; i++) wbuf.push_back(8'($urandom));
        do_write(addr, $urandom_range(0, 15));
      end else begin
        do_read(addr, len, $urandom_range(0, 15));
      end
    end
    rr_mode = 0;
    br_mode = 0;
    delay   = 0;

    // Reset in the middle of both bursts
    aw_req(8'h40, 12);
    w_beat(8'h9E, 0);
    ref_mem[8'h40] = 8'h9E;
    w_beat(8'h9F, 0);
    ref_mem[8'h41] = 8'h9F;
    rr_mode = 3;
    ar_req(8'h50, 3, 13);
    @(negedge clk);
    chk("pre_rst_rvalid", ifc.RVALID, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {ifc.RVALID, ifc.BVALID, ifc.WREADY, ifc.ARREADY, ifc.AWREADY, ridle, widle}, 7'b0000011);
    rq.delete();
    bq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rr_mode = 0;
    @(posedge clk); #1;
    do_read(8'h40, 1, 14);

    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
